// File: rtl/hb_dec_seq.sv
// hb_dec_seq: sequencer and MAC datapath for a 15-tap halfband decimate-by-2
// FIR. Samples are written into an external 16x16 dual-read RAM; every second
// sample starts a walk over the 4 symmetric tap pairs plus the centre tap,
// pre-add -> multiply -> accumulate, then round/saturate to one output sample.
module hb_dec_seq (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        strobe_in,
    input  logic [15:0] data_in,
    output logic        ram_write,
    output logic [3:0]  ram_wr_addr,
    output logic [15:0] ram_wr_data,
    output logic [3:0]  ram_rd_addr1,
    input  logic [15:0] ram_rd_data1,
    output logic [3:0]  ram_rd_addr2,
    input  logic [15:0] ram_rd_data2,
    output logic        strobe_out,
    output logic [15:0] data_out,
    output logic        overrun
);

    localparam int unsigned DW   = 16;        // sample width
    localparam int unsigned AW   = 4;         // RAM address width
    localparam int unsigned PW   = DW + 1;    // pre-adder width
    localparam int unsigned CW   = 16;        // coefficient width
    localparam int unsigned MW   = PW + CW;   // product width
    localparam int unsigned ACCW = 36;        // accumulator width
    localparam int unsigned KW   = 3;         // term index width
    localparam int unsigned SH   = 15;        // Q1.15 scaling shift

    localparam logic signed [CW-1:0] C0 = -16'sd256;
    localparam logic signed [CW-1:0] C1 = 16'sd1024;
    localparam logic signed [CW-1:0] C2 = -16'sd2560;
    localparam logic signed [CW-1:0] C3 = 16'sd9984;
    localparam logic signed [CW-1:0] CC = 16'sd16384;

    localparam logic [AW-1:0] FILL_FULL = 4'd15;
    localparam logic [KW-1:0] LAST_K    = 3'd4;
    localparam logic [1:0]    LAST_DR   = 2'd3;

    localparam logic signed [ACCW-1:0] RND     = 36'sd16384;
    localparam logic signed [ACCW-1:0] SAT_MAX = 36'sd32767;
    localparam logic signed [ACCW-1:0] SAT_MIN = -36'sd32768;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // control state
    state_t          state_q;
    logic [AW-1:0]   wr_ptr_q;
    logic            phase_q;
    logic [AW-1:0]   fill_q;
    logic [AW-1:0]   base_q;
    logic [KW-1:0]   k_q;
    logic [1:0]      drain_q;
    logic            fire_q;
    logic [AW-1:0]   rd_addr1_q;
    logic [AW-1:0]   rd_addr2_q;
    logic            strobe_out_q;
    logic [DW-1:0]   data_out_q;
    logic            overrun_q;

    // datapath pipeline
    logic                    rdv_q;
    logic [KW-1:0]           rdk_q;
    logic                    psv_q;
    logic [KW-1:0]           psk_q;
    logic signed [PW-1:0]    presum_q;
    logic signed [PW-1:0]    presum_d;
    logic                    prv_q;
    logic [KW-1:0]           prk_q;
    logic signed [MW-1:0]    product_q;
    logic signed [MW-1:0]    product_d;
    logic signed [ACCW-1:0]  acc_q;
    logic signed [ACCW-1:0]  acc_d;

    // combinational helpers
    logic                    start_c;
    logic                    drop_c;
    logic [KW-1:0]           k_nxt_c;
    logic [AW-1:0]           two_k_c;
    logic [AW-1:0]           addr1_nxt_c;
    logic [AW-1:0]           addr2_nxt_c;
    logic signed [DW-1:0]    rd1_s;
    logic signed [DW-1:0]    rd2_s;
    logic signed [CW-1:0]    coef_c;
    logic signed [ACCW-1:0]  rnd_c;
    logic signed [ACCW-1:0]  shf_c;
    logic signed [DW-1:0]    sat_c;

    // write side is a straight pass-through so a write is never blocked
    assign ram_write    = strobe_in;
    assign ram_wr_addr  = wr_ptr_q;
    assign ram_wr_data  = data_in;
    assign ram_rd_addr1 = rd_addr1_q;
    assign ram_rd_addr2 = rd_addr2_q;
    assign strobe_out   = strobe_out_q;
    assign data_out     = data_out_q;
    assign overrun      = overrun_q;

    assign rd1_s = ram_rd_data1;
    assign rd2_s = ram_rd_data2;

    // odd-phase sample either starts a computation or is dropped as overrun
    assign start_c = strobe_in & phase_q & (state_q == ST_IDLE);
    assign drop_c  = strobe_in & phase_q & (state_q != ST_IDLE);

    // read addresses for the next issue term: pair k walks inward from both ends
    always_comb begin
        k_nxt_c     = k_q + 3'd1;
        two_k_c     = {k_nxt_c, 1'b0};
        addr1_nxt_c = base_q - two_k_c;
        addr2_nxt_c = base_q + 4'd2 + two_k_c;
        if (k_nxt_c == LAST_K) begin
            addr1_nxt_c = base_q - 4'd7;
            addr2_nxt_c = base_q - 4'd7;
        end
    end

    // coefficient for the term sitting in the multiplier stage
    always_comb begin
        coef_c = CC;
        case (psk_q)
            3'd0:    coef_c = C0;
            3'd1:    coef_c = C1;
            3'd2:    coef_c = C2;
            3'd3:    coef_c = C3;
            default: coef_c = CC;
        endcase
    end

    // pre-add, multiply and accumulate next values
    always_comb begin
        presum_d = {rd1_s[DW-1], rd1_s} + {rd2_s[DW-1], rd2_s};
        if (rdk_q == LAST_K) begin
            presum_d = {rd1_s[DW-1], rd1_s};
        end
        product_d = MW'(presum_q) * MW'(coef_c);
        acc_d     = acc_q + ACCW'(product_q);
        if (prk_q == '0) begin
            acc_d = ACCW'(product_q);
        end
    end

    // round half-up in Q1.15, then clamp to the 16-bit signed range
    always_comb begin
        rnd_c = acc_q + RND;
        shf_c = rnd_c >>> SH;
        sat_c = shf_c[DW-1:0];
        if (shf_c > SAT_MAX) begin
            sat_c = 16'sh7FFF;
        end else if (shf_c < SAT_MIN) begin
            sat_c = 16'sh8000;
        end
    end

    // input bookkeeping: write pointer, decimation phase, priming fill count
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            phase_q   <= 1'b0;
            fill_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (strobe_in) begin
                wr_ptr_q <= wr_ptr_q + 4'd1;
                phase_q  <= ~phase_q;
                if (fill_q != FILL_FULL) begin
                    fill_q <= fill_q + 4'd1;
                end
            end
            if (drop_c) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // sequencer FSM: issue 5 read terms, wait out the pipeline, emit result
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            k_q          <= '0;
            drain_q      <= '0;
            fire_q       <= 1'b0;
            rd_addr1_q   <= '0;
            rd_addr2_q   <= '0;
            strobe_out_q <= 1'b0;
            data_out_q   <= '0;
        end else begin
            strobe_out_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_c) begin
                        state_q    <= ST_ISSUE;
                        base_q     <= wr_ptr_q;
                        k_q        <= '0;
                        fire_q     <= (fill_q == FILL_FULL);
                        rd_addr1_q <= wr_ptr_q;
                        rd_addr2_q <= wr_ptr_q + 4'd2;
                    end
                end
                ST_ISSUE: begin
                    if (k_q == LAST_K) begin
                        state_q <= ST_DRAIN;
                        drain_q <= '0;
                    end else begin
                        k_q        <= k_nxt_c;
                        rd_addr1_q <= addr1_nxt_c;
                        rd_addr2_q <= addr2_nxt_c;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == LAST_DR) begin
                        state_q <= ST_IDLE;
                        if (fire_q) begin
                            strobe_out_q <= 1'b1;
                            data_out_q   <= sat_c;
                        end
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // read-data / pre-add / multiply / accumulate pipeline with term tags
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rdv_q     <= 1'b0;
            rdk_q     <= '0;
            psv_q     <= 1'b0;
            psk_q     <= '0;
            presum_q  <= '0;
            prv_q     <= 1'b0;
            prk_q     <= '0;
            product_q <= '0;
            acc_q     <= '0;
        end else begin
            rdv_q <= (state_q == ST_ISSUE);
            rdk_q <= k_q;
            psv_q <= rdv_q;
            psk_q <= rdk_q;
            if (rdv_q) begin
                presum_q <= presum_d;
            end
            prv_q <= psv_q;
            prk_q <= psk_q;
            if (psv_q) begin
                product_q <= product_d;
            end
            if (prv_q) begin
                acc_q <= acc_d;
            end
        end
    end

endmodule
